// File: rtl/divide_arbiter.sv
// divide_arbiter
//   Shares one fully pipelined fixed-point divider among NUM_REQ requesters.
//   Requests are granted round-robin through valid/ready handshakes. A tag
//   pipeline follows every operation, and each result is handed back to its
//   owner as a one-cycle pulse 27 cycles after the accept. Each requester is
//   limited to MAX_OUTSTANDING operations in flight. A ratio that does not fit
//   in Q1.25 is saturated and flagged.
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous active-high reset
//   req_valid_in   per-requester request valid
//   req_ready_out  per-requester accept (one-hot or zero)
//   dividend_in    requester i dividend at [24i+23:24i]
//   divisor_in     requester i divisor at [24i+23:24i]
//   res_valid_out  one-cycle result pulse for the owner (one-hot or zero)
//   quotient_out   registered Q1.25 quotient, valid with res_valid_out
//   res_ovf_out    out-of-range flag, valid with res_valid_out
module divide_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [NUM_REQ-1:0]        req_valid_in,
   output logic [NUM_REQ-1:0]        req_ready_out,
   input  logic [24*NUM_REQ-1:0]     dividend_in,
   input  logic [24*NUM_REQ-1:0]     divisor_in,
   output logic [NUM_REQ-1:0]        res_valid_out,
   output logic [25:0]               quotient_out,
   output logic                      res_ovf_out
);
   localparam int DATA_W     = 24;
   localparam int QUO_W      = 26;
   localparam int STAGES     = 26;
   localparam int TAG_STAGES = STAGES + 1;
   localparam int CNT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W      = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   function automatic logic [QUO_W-1:0] sat_quotient(input logic ovf, input logic [QUO_W-1:0] q);
      return ovf ? {QUO_W{1'b1}} : q;
   endfunction

   // Quotient fits Q1.25 only when dividend < 2*divisor; this also catches divisor = 0.
   function automatic logic range_ovf(input logic [DATA_W-1:0] dvd, input logic [DATA_W-1:0] dvs);
      return {1'b0, dvd} >= {dvs, 1'b0};
   endfunction

   // The first step resolves the integer bit, so the remainder is not shifted.
   function automatic logic [DATA_W:0] div_trial(input logic [DATA_W:0] rem, input logic first);
      return first ? rem : {rem[DATA_W-1:0], 1'b0};
   endfunction

   logic [NUM_REQ-1:0][CNT_W-1:0]    outstanding;
   logic [PTR_W-1:0]                 rr_ptr;
   logic [NUM_REQ-1:0]               eligible;
   logic                             grant_found;
   logic [PTR_W-1:0]                 grant_idx;
   logic [PTR_W-1:0]                 ptr_next;
   logic                             accept;
   logic [DATA_W-1:0]                dvd_sel;
   logic [DATA_W-1:0]                dvs_sel;

   logic [TAG_STAGES-1:0]            tag_vld_p;
   logic [TAG_STAGES-1:0][PTR_W-1:0] tag_own_p;
   logic [TAG_STAGES-1:0]            tag_ovf_p;

   logic [DATA_W:0]                  rem_p [0:STAGES-1];
   logic [DATA_W-1:0]                dvs_p [0:STAGES-1];
   logic [QUO_W-1:0]                 quo_p [1:STAGES];
   logic [DATA_W:0]                  trial_c [1:STAGES];
   logic [STAGES:1]                  qbit_c;

   // A requester at its limit may still be granted in its own result cycle,
   // because that pulse frees a slot at the same edge.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid_in[i] && ((outstanding[i] < CNT_MAX) || res_valid_out[i]);
      end
   end

   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_found && eligible[idx]) begin
            grant_found = 1'b1;
            grant_idx   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready_out = '0;
      if (!rst_in && grant_found) begin
         req_ready_out[grant_idx] = 1'b1;
      end
   end

   assign accept   = |(req_valid_in & req_ready_out);
   assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
   assign dvd_sel  = dividend_in[int'(grant_idx)*DATA_W +: DATA_W];
   assign dvs_sel  = divisor_in[int'(grant_idx)*DATA_W +: DATA_W];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rr_ptr      <= '0;
         outstanding <= '0;
      end else begin
         if (accept) begin
            rr_ptr <= ptr_next;
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (int'(grant_idx) == i) && !res_valid_out[i]) begin
               outstanding[i] <= outstanding[i] + CNT_W'(1);
            end else if (res_valid_out[i] && !(accept && (int'(grant_idx) == i))) begin
               outstanding[i] <= outstanding[i] - CNT_W'(1);
            end
         end
      end
   end

   // Stage p0: tag capture at accept; p1..p26: shift alongside the divider.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         tag_vld_p <= '0;
         tag_own_p <= '0;
         tag_ovf_p <= '0;
      end else begin
         tag_vld_p <= {tag_vld_p[TAG_STAGES-2:0], accept};
         tag_own_p <= {tag_own_p[TAG_STAGES-2:0], grant_idx};
         tag_ovf_p <= {tag_ovf_p[TAG_STAGES-2:0], range_ovf(dvd_sel, dvs_sel)};
      end
   end

   always_comb begin
      for (int s = 1; s <= STAGES; s++) begin
         trial_c[s] = div_trial(rem_p[s-1], s == 1);
         qbit_c[s]  = trial_c[s] >= {1'b0, dvs_p[s-1]};
      end
   end

   // Stage p0: operand capture; p1..p26: one restoring-division quotient bit each.
   always_ff @(posedge clk_in) begin
      rem_p[0] <= {1'b0, dvd_sel};
      dvs_p[0] <= dvs_sel;
      for (int s = 1; s < STAGES; s++) begin
         rem_p[s] <= qbit_c[s] ? trial_c[s] - {1'b0, dvs_p[s-1]} : trial_c[s];
         dvs_p[s] <= dvs_p[s-1];
      end
      quo_p[1] <= {{(QUO_W-1){1'b0}}, qbit_c[1]};
      for (int s = 2; s <= STAGES; s++) begin
         quo_p[s] <= {quo_p[s-1][QUO_W-2:0], qbit_c[s]};
      end
   end

   // Output stage: result register, 27 edges after the accept.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         res_valid_out <= '0;
         quotient_out  <= '0;
         res_ovf_out   <= 1'b0;
      end else begin
         res_valid_out <= '0;
         if (tag_vld_p[TAG_STAGES-1]) begin
            res_valid_out[tag_own_p[TAG_STAGES-1]] <= 1'b1;
         end
         quotient_out <= sat_quotient(tag_ovf_p[TAG_STAGES-1], quo_p[STAGES]);
         res_ovf_out  <= tag_vld_p[TAG_STAGES-1] & tag_ovf_p[TAG_STAGES-1];
      end
   end
endmodule
